// File: rtl/multicycle_alu.sv
// Multi-cycle EX-stage execution unit: single-cycle ADD/SUB, iterative
// shift-add MUL and restoring DIV behind a start/busy/done handshake.
module multicycle_alu #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       ctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic             div_by_zero,
  output logic             illegal_op
);

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_MUL = 4'b0100;
  localparam logic [3:0] OP_DIV = 4'b1000;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  // Two's-complement overflow of a +/- b, detected on a one-bit-wider sum.
  function automatic logic signed_ovf(input logic signed [WIDTH-1:0] a,
                                      input logic signed [WIDTH-1:0] b,
                                      input logic                    sub);
    logic signed [WIDTH:0] a_x;
    logic signed [WIDTH:0] b_x;
    logic signed [WIDTH:0] wide;
    a_x  = {a[WIDTH-1], a};
    b_x  = {b[WIDTH-1], b};
    wide = sub ? (a_x - b_x) : (a_x + b_x);
    return wide[WIDTH] ^ wide[WIDTH-1];
  endfunction

  logic [1:0]              state;
  logic [CNT_W-1:0]        cnt;
  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;
  logic signed [WIDTH-1:0] sum_s;
  logic signed [WIDTH-1:0] diff_s;

  logic [WIDTH-1:0]        hi_p0;
  logic [WIDTH-1:0]        lo_p0;
  logic [WIDTH-1:0]        opnd_p0;
  logic [WIDTH-1:0]        hi_nxt;
  logic [WIDTH-1:0]        lo_nxt;
  logic [WIDTH:0]          mul_sum;
  logic [WIDTH:0]          div_shift;
  logic [WIDTH:0]          div_diff;

  logic [WIDTH-1:0]        res_lo_p1;
  logic [WIDTH-1:0]        res_hi_p1;
  logic                    ovf_p1;
  logic                    dbz_p1;
  logic                    ill_p1;
  logic                    vld_p1;

  assign a_s    = op_a;
  assign b_s    = op_b;
  assign sum_s  = a_s + b_s;
  assign diff_s = a_s - b_s;

  // Stage 0: operand capture for the iterative ops, then one MUL/DIV step per cycle.
  // hi_p0 holds the partial product / partial remainder; lo_p0 shifts out the
  // multiplier or dividend while the product low half / quotient shifts in.
  always_ff @(posedge clk) begin
    if (state == S_IDLE) begin
      if (start) begin
        hi_p0   <= '0;
        lo_p0   <= (ctrl == OP_MUL) ? op_b : op_a;
        opnd_p0 <= (ctrl == OP_MUL) ? op_a : op_b;
      end
    end else begin
      hi_p0 <= hi_nxt;
      lo_p0 <= lo_nxt;
    end
  end

  always_comb begin
    hi_nxt    = hi_p0;
    lo_nxt    = lo_p0;
    mul_sum   = '0;
    div_shift = '0;
    div_diff  = '0;
    if (state == S_MUL) begin
      mul_sum = {1'b0, hi_p0} + (lo_p0[0] ? {1'b0, opnd_p0} : '0);
      hi_nxt  = mul_sum[WIDTH:1];
      lo_nxt  = {mul_sum[0], lo_p0[WIDTH-1:1]};
    end else if (state == S_DIV) begin
      div_shift = {hi_p0, lo_p0[WIDTH-1]};
      div_diff  = div_shift - {1'b0, opnd_p0};
      if (div_diff[WIDTH]) begin
        hi_nxt = div_shift[WIDTH-1:0];
        lo_nxt = {lo_p0[WIDTH-2:0], 1'b0};
      end else begin
        hi_nxt = div_diff[WIDTH-1:0];
        lo_nxt = {lo_p0[WIDTH-2:0], 1'b1};
      end
    end
  end

  // Stage 1: sequencing and the result/flag register, written only on completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      vld_p1    <= 1'b0;
      res_lo_p1 <= '0;
      res_hi_p1 <= '0;
      ovf_p1    <= 1'b0;
      dbz_p1    <= 1'b0;
      ill_p1    <= 1'b0;
    end else begin
      vld_p1 <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            cnt <= '0;
            case (ctrl)
              OP_ADD: begin
                res_lo_p1 <= sum_s;
                res_hi_p1 <= '0;
                ovf_p1    <= signed_ovf(a_s, b_s, 1'b0);
                dbz_p1    <= 1'b0;
                ill_p1    <= 1'b0;
                vld_p1    <= 1'b1;
              end
              OP_SUB: begin
                res_lo_p1 <= diff_s;
                res_hi_p1 <= '0;
                ovf_p1    <= signed_ovf(a_s, b_s, 1'b1);
                dbz_p1    <= 1'b0;
                ill_p1    <= 1'b0;
                vld_p1    <= 1'b1;
              end
              OP_MUL: state <= S_MUL;
              OP_DIV: begin
                if (op_b == '0) begin
                  res_lo_p1 <= '1;
                  res_hi_p1 <= op_a;
                  ovf_p1    <= 1'b0;
                  dbz_p1    <= 1'b1;
                  ill_p1    <= 1'b0;
                  vld_p1    <= 1'b1;
                end else begin
                  state <= S_DIV;
                end
              end
              default: begin
                res_lo_p1 <= '0;
                res_hi_p1 <= '0;
                ovf_p1    <= 1'b0;
                dbz_p1    <= 1'b0;
                ill_p1    <= 1'b1;
                vld_p1    <= 1'b1;
              end
            endcase
          end
        end
        S_MUL, S_DIV: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST_ITER) begin
            state     <= S_IDLE;
            res_lo_p1 <= lo_nxt;
            res_hi_p1 <= hi_nxt;
            ovf_p1    <= 1'b0;
            dbz_p1    <= 1'b0;
            ill_p1    <= 1'b0;
            vld_p1    <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy        = (state != S_IDLE);
  assign done        = vld_p1;
  assign result_lo   = res_lo_p1;
  assign result_hi   = res_hi_p1;
  assign ovf         = ovf_p1;
  assign div_by_zero = dbz_p1;
  assign illegal_op  = ill_p1;

endmodule

// File: tb/tb_multicycle_alu.sv
// Scoreboard bench for multicycle_alu: a driver pushes expected results from an
// arithmetic reference model, a negedge monitor pops them when done is seen.
module tb_multicycle_alu;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [3:0]   ctrl;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [W-1:0] result_lo;
  logic [W-1:0] result_hi;
  logic         busy;
  logic         done;
  logic         ovf;
  logic         div_by_zero;
  logic         illegal_op;

  multicycle_alu #(.WIDTH(W), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ctrl(ctrl),
    .op_a(op_a), .op_b(op_b),
    .result_lo(result_lo), .result_hi(result_hi),
    .busy(busy), .done(done), .ovf(ovf),
    .div_by_zero(div_by_zero), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         ovf;
    logic         dbz;
    logic         ill;
    int           issue;
    int           lat;
  } exp_t;

  exp_t         sb_q[$];
  int           n_cmp = 0;
  int           n_err = 0;
  int           cyc = 0;
  int           free_cyc = 0;
  int           busy_from = 1;
  int           busy_to = 0;
  logic [W-1:0] ref_lo = '0;
  logic [W-1:0] ref_hi = '0;
  logic         ref_ovf = 1'b0;
  logic         ref_dbz = 1'b0;
  logic         ref_ill = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp_v);
    end
  endtask

  // Reference: plain integer arithmetic on the operation's definition.
  function automatic exp_t model(input logic [3:0] c, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input int issue);
    exp_t   e;
    longint sa;
    longint sbv;
    longint s;
    longint p;
    e.lo = '0; e.hi = '0; e.ovf = 1'b0; e.dbz = 1'b0; e.ill = 1'b0;
    e.issue = issue;
    e.lat = 1;
    sa  = (a >= W'(1 << (W - 1))) ? longint'(a) - longint'(1 << W) : longint'(a);
    sbv = (b >= W'(1 << (W - 1))) ? longint'(b) - longint'(1 << W) : longint'(b);
    case (c)
      4'b0001: begin
        s = sa + sbv;
        e.lo = a + b;
        e.ovf = (s > longint'((1 << (W - 1)) - 1)) || (s < -longint'(1 << (W - 1)));
      end
      4'b0010: begin
        s = sa - sbv;
        e.lo = a - b;
        e.ovf = (s > longint'((1 << (W - 1)) - 1)) || (s < -longint'(1 << (W - 1)));
      end
      4'b0100: begin
        p = longint'(a) * longint'(b);
        e.lo = p[W-1:0];
        e.hi = p[2*W-1:W];
        e.lat = W + 1;
      end
      4'b1000: begin
        if (b == '0) begin
          e.lo = '1;
          e.hi = a;
          e.dbz = 1'b1;
        end else begin
          e.lo = a / b;
          e.hi = a % b;
          e.lat = W + 1;
        end
      end
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  // Monitor: compares on every falling edge, decoupled from the driver.
  always @(negedge clk) begin : monitor
    exp_t e;
    logic exp_busy;
    if (!rst_n) begin
      check("reset_outputs", 64'({result_hi, result_lo, ovf, div_by_zero, illegal_op, done, busy}), 64'(0));
    end else begin
      exp_busy = (cyc >= busy_from) && (cyc <= busy_to);
      check("busy", 64'(busy), 64'(exp_busy));
      if (done) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_done at cycle %0d: got done=1, expected no completion", cyc);
        end else begin
          e = sb_q.pop_front();
          check("result_lo", 64'(result_lo), 64'(e.lo));
          check("result_hi", 64'(result_hi), 64'(e.hi));
          check("ovf", 64'(ovf), 64'(e.ovf));
          check("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
          check("illegal_op", 64'(illegal_op), 64'(e.ill));
          check("latency", 64'(cyc - e.issue), 64'(e.lat));
          ref_lo = e.lo; ref_hi = e.hi; ref_ovf = e.ovf; ref_dbz = e.dbz; ref_ill = e.ill;
        end
      end else begin
        check("hold", 64'({result_hi, result_lo, ovf, div_by_zero, illegal_op}),
              64'({ref_hi, ref_lo, ref_ovf, ref_dbz, ref_ill}));
      end
    end
  end

  task automatic gap(input int n);
    repeat (n) begin
      @(negedge clk); #1;
      start = 1'b0;
    end
  endtask

  // Waits for the DUT to be free, pulsing stray starts while it is busy.
  task automatic issue(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    forever begin
      @(negedge clk); #1;
      if (cyc >= free_cyc) break;
      start = ($urandom_range(0, 2) == 0);
      ctrl  = 4'($urandom);
      op_a  = W'($urandom);
      op_b  = W'($urandom);
    end
    start = 1'b1;
    ctrl  = c;
    op_a  = a;
    op_b  = b;
    e = model(c, a, b, cyc);
    sb_q.push_back(e);
    free_cyc = cyc + e.lat;
    if (e.lat > 1) begin
      busy_from = cyc + 1;
      busy_to   = cyc + W;
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    gap(1);
    while (sb_q.size() != 0 && guard < 100) begin
      gap(1);
      guard++;
    end
    check("drain_empty", 64'(sb_q.size()), 64'(0));
  endtask

  function automatic logic [W-1:0] rand_opnd();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return W'(1 << (W - 1));
      3:       return W'((1 << (W - 1)) - 1);
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [3:0]   c;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           r;
    rst_n = 1'b0;
    start = 1'b0;
    ctrl  = '0;
    op_a  = '0;
    op_b  = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_result_lo", 64'(result_lo), 64'(0));
    check("rst_result_hi", 64'(result_hi), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_flags", 64'({ovf, div_by_zero, illegal_op}), 64'(0));
    rst_n = 1'b1;
    free_cyc = cyc;

    issue(4'b0001, 16'h7FFF, 16'h0001);
    issue(4'b0010, 16'h0005, 16'h0007);
    issue(4'b0100, 16'hFFFF, 16'hFFFF);
    issue(4'b1000, 16'd100, 16'd7);
    issue(4'b1000, 16'd5, 16'd0);
    issue(4'b0011, 16'h1234, 16'h5678);
    gap(2);

    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 9);
      a = rand_opnd();
      b = rand_opnd();
      case (r)
        0, 1: c = 4'b0001;
        2, 3: c = 4'b0010;
        4, 5: c = 4'b0100;
        6, 7: c = 4'b1000;
        8: begin
          do c = 4'($urandom); while (c == 4'b0001 || c == 4'b0010 || c == 4'b0100 || c == 4'b1000);
        end
        default: begin
          c = 4'b1000;
          b = '0;
        end
      endcase
      issue(c, a, b);
      if ($urandom_range(0, 4) == 0) gap($urandom_range(1, 3));
    end
    drain();

    // Abort a multiply mid-iteration: outputs clear at once and no done follows.
    issue(4'b0001, 16'h0001, 16'h0002);
    issue(4'b0100, 16'hBEEF, 16'h1234);
    gap(8);
    rst_n = 1'b0;
    #1;
    check("abort_result", 64'({result_hi, result_lo}), 64'(0));
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    check("abort_flags", 64'({ovf, div_by_zero, illegal_op}), 64'(0));
    sb_q.delete();
    ref_lo = '0; ref_hi = '0; ref_ovf = 1'b0; ref_dbz = 1'b0; ref_ill = 1'b0;
    busy_from = 1;
    busy_to = 0;
    gap(3);
    rst_n = 1'b1;
    free_cyc = cyc;
    gap(W + 4);
    issue(4'b0001, 16'h1111, 16'h2222);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
